q2_uart_tx: RTL

- Memory-mapped serial output peripheral on the q2 CPU bus, downstream of the core.
- Consumes CPU writes to the console address (12'hFFF), buffers them in a small FIFO, and serialises the low 8 bits as 8N1 UART frames.
- Exposes a read-only status word at 12'hFFE so software can poll before writing.
- Replaces the bench-level OUTPUT print with real hardware on the board build.

---
 rtl/q2_uart_pkg.sv | 23 ++
 rtl/q2_uart_fifo.sv | 50 +++++
 rtl/q2_uart_tx.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/q2_uart_pkg.sv
// Shared types and constants for the q2 console UART transmitter.
package q2_uart_pkg;

    // TX FSM states; PARITY is only reachable when parity is built in
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Default bus addresses
    localparam logic [11:0] TX_ADDR_DEF   = 12'hFFF;
    localparam logic [11:0] STAT_ADDR_DEF = 12'hFFE;

    // Bit positions inside the status word
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_BUSY  = 3;

endpackage

// File: rtl/q2_uart_fifo.sv
// Small first-word fall-through FIFO for the console UART.
// Pointers carry one extra wrap bit so full and empty are unambiguous.
module q2_uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A push while full is still accepted when the head leaves in the same cycle
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr[AW-1:0]] <= din;
    end

    // Pointer advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/q2_uart_tx.sv
// Memory-mapped console UART transmitter for the q2 CPU bus.
// Writes to TX_ADDR queue a byte; STAT_ADDR reads return {busy, ovf, full, empty}.
// Frames are 8N1; defining Q2_UART_PARITY_EN inserts an even parity bit (8E1).
module q2_uart_tx
    import q2_uart_pkg::*;
#(
    parameter int          CLK_DIV    = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [11:0] TX_ADDR    = TX_ADDR_DEF,
    parameter logic [11:0] STAT_ADDR  = STAT_ADDR_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] abus,
    inout  wire  [11:0] dbus,
    input  logic        wrm,
    input  logic        rdm,
    output logic        tx,
    output logic        busy
);

    localparam int             BW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLK_DIV - 1);

    state_t        state, state_nxt;
    logic [BW-1:0] baud_cnt, baud_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    sh, sh_nxt;
    logic          tx_nxt;
`ifdef Q2_UART_PARITY_EN
    logic          par, par_nxt;
`endif

    logic          wrm_q, rdm_q;
    logic          overflow;
    logic          wr_ev, rd_ev, ovf_set;
    logic          pop;
    logic          full, empty;
    logic [7:0]    fifo_dout;
    logic [3:0]    stat;
    logic          unused_dbus_hi;

    // Upper data bits carry nothing for the console
    assign unused_dbus_hi = ^dbus[11:8];

    // Rising edges of the bus strobes qualified by address
    assign wr_ev   = wrm && !wrm_q && (abus == TX_ADDR);
    assign rd_ev   = rdm && !rdm_q && (abus == STAT_ADDR);
    assign ovf_set = wr_ev && full && !pop;

    q2_uart_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_ev),
        .pop   (pop),
        .din   (dbus[7:0]),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty)
    );

    assign stat[STAT_EMPTY] = empty;
    assign stat[STAT_FULL]  = full;
    assign stat[STAT_OVF]   = overflow;
    assign stat[STAT_BUSY]  = busy;

    assign dbus = (rdm && (abus == STAT_ADDR)) ? {8'b0, stat} : 12'bz;

    // Strobe history, sticky overflow (a set beats a same-cycle clear), busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrm_q    <= 1'b0;
            rdm_q    <= 1'b0;
            overflow <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wrm_q <= wrm;
            rdm_q <= rdm;
            if (ovf_set)
                overflow <= 1'b1;
            else if (rd_ev)
                overflow <= 1'b0;
            busy <= !empty || (state != IDLE);
        end
    end

    // TX state register; tx is registered so the line never glitches
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            tx       <= 1'b1;
`ifdef Q2_UART_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            baud_cnt <= baud_nxt;
            bit_cnt  <= bit_nxt;
            sh       <= sh_nxt;
            tx       <= tx_nxt;
`ifdef Q2_UART_PARITY_EN
            par      <= par_nxt;
`endif
        end
    end

    // TX next-state, bit timing and line value for the next cycle
    always_comb begin
        state_nxt = state;
        baud_nxt  = baud_cnt + 1'b1;
        bit_nxt   = bit_cnt;
        sh_nxt    = sh;
        pop       = 1'b0;
`ifdef Q2_UART_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            IDLE: begin
                baud_nxt = '0;
                if (!empty) begin
                    pop       = 1'b1;
                    sh_nxt    = fifo_dout;
                    state_nxt = START;
`ifdef Q2_UART_PARITY_EN
                    par_nxt   = ^fifo_dout;
`endif
                end
            end
            START: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    bit_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt = '0;
                    sh_nxt   = {1'b0, sh[7:1]};
                    bit_nxt  = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
`ifdef Q2_UART_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef Q2_UART_PARITY_EN
            PARITY: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_cnt == BAUD_LAST) begin
                    baud_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                baud_nxt  = '0;
                state_nxt = IDLE;
            end
        endcase

        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = sh_nxt[0];
`ifdef Q2_UART_PARITY_EN
            PARITY:  tx_nxt = par_nxt;
`endif
            default: tx_nxt = 1'b1;
        endcase
    end

endmodule
